shift_reg_pipe: RTL and testbench

Parametrised multi-stage register pipeline with per-stage valid tracking, the next generation of our single-bit D flip-flop stage. It delays a DWIDTH-bit word by DEPTH clock-enabled stages and adds rotate, parallel load, synchronous clear and a selectable output tap. It is a building block for alignment delays and serial/parallel conversion in the sequential-logic library.

---
 rtl/shift_reg_pkg.sv | 12 +
 rtl/shift_stage.sv | 40 ++++
 rtl/shift_reg_pipe.sv | 105 ++++++++++
 tb/tb_shift_reg_pipe.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// Purpose: shared operation-mode encodings for the shift_reg_pipe family.
// Latency: n/a (constants only).
// Backpressure: n/a.
package shift_reg_pkg;

   // Operation select driven on i_mode
   localparam logic [1:0] MODE_HOLD   = 2'b00;
   localparam logic [1:0] MODE_SHIFT  = 2'b01;
   localparam logic [1:0] MODE_ROTATE = 2'b10;
   localparam logic [1:0] MODE_LOAD   = 2'b11;

endpackage

// File: rtl/shift_stage.sv
// Purpose: one pipeline stage, a DWIDTH data register plus its valid bit.
// Latency: 1 clock from i_d/i_v to o_q/o_v when enabled and loading.
// Backpressure: none; i_en=0 or i_ld=0 simply holds the stage.
// Ports: i_clk, i_rstn (async active-low), i_clr (sync clear), i_en (advance),
//        i_ld (capture i_d/i_v this edge), i_d/i_v (next value), o_q/o_v (state).
module shift_stage #(
   parameter int DWIDTH = 8
) (
   input  logic              i_clk,
   input  logic              i_rstn,
   input  logic              i_clr,
   input  logic              i_en,
   input  logic              i_ld,
   input  logic [DWIDTH-1:0] i_d,
   input  logic              i_v,
   output logic [DWIDTH-1:0] o_q,
   output logic              o_v
);

   logic [DWIDTH-1:0] r_q;
   logic              r_v;

   // Clear outranks enable; enable outranks the capture request.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_q <= '0;
         r_v <= 1'b0;
      end else if (i_clr) begin
         r_q <= '0;
         r_v <= 1'b0;
      end else if (i_en && i_ld) begin
         r_q <= i_d;
         r_v <= i_v;
      end
   end

   assign o_q = r_q;
   assign o_v = r_v;

endmodule

// File: rtl/shift_reg_pipe.sv
// Purpose: DEPTH-stage clock-enabled register pipe with shift/rotate/load/clear
//          and a selectable combinational tap.
// Latency: SHIFT word reaches o_q after DEPTH enabled edges; LOAD visible after 1.
// Backpressure: none; i_en=0 freezes every stage, disabled cycles add latency 1:1.
// Ports: i_clk, i_rstn, i_clr, i_en, i_mode, i_d (serial in), i_pd (parallel in),
//        i_tap_sel; o_q/o_valid (last stage), o_tap/o_tap_valid (selected stage),
//        o_pq (all stages, stage k at [k*DWIDTH +: DWIDTH]).
module shift_reg_pipe
   import shift_reg_pkg::*;
#(
   parameter int DWIDTH = 8,
   parameter int DEPTH  = 4,
   parameter int TWIDTH = $clog2(DEPTH)
) (
   input  logic                     i_clk,
   input  logic                     i_rstn,
   input  logic                     i_clr,
   input  logic                     i_en,
   input  logic [1:0]               i_mode,
   input  logic [DWIDTH-1:0]        i_d,
   input  logic [DWIDTH*DEPTH-1:0]  i_pd,
   input  logic [TWIDTH-1:0]        i_tap_sel,
   output logic [DWIDTH-1:0]        o_q,
   output logic                     o_valid,
   output logic [DWIDTH-1:0]        o_tap,
   output logic                     o_tap_valid,
   output logic [DWIDTH*DEPTH-1:0]  o_pq
);

   logic [DWIDTH-1:0] w_s  [DEPTH];
   logic              w_v  [DEPTH];
   logic [DWIDTH-1:0] w_nd [DEPTH];
   logic              w_nv [DEPTH];
   logic              w_ld;

   // HOLD is the only mode that leaves the stages untouched.
   assign w_ld = (i_mode != MODE_HOLD);

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      // Next-value mux. Every stage reads the registered (pre-edge) value of
      // its predecessor, so the pipe always advances exactly one stage per edge.
      if (k == 0) begin : g_head
         always_comb begin
            w_nd[k] = i_d;
            w_nv[k] = 1'b1;
            case (i_mode)
               MODE_ROTATE: begin
                  w_nd[k] = w_s[DEPTH-1];
                  w_nv[k] = w_v[DEPTH-1];
               end
               MODE_LOAD: begin
                  w_nd[k] = i_pd[k*DWIDTH +: DWIDTH];
                  w_nv[k] = 1'b1;
               end
               default: begin
                  w_nd[k] = i_d;
                  w_nv[k] = 1'b1;
               end
            endcase
         end
      end else begin : g_body
         always_comb begin
            w_nd[k] = w_s[k-1];
            w_nv[k] = w_v[k-1];
            if (i_mode == MODE_LOAD) begin
               w_nd[k] = i_pd[k*DWIDTH +: DWIDTH];
               w_nv[k] = 1'b1;
            end
         end
      end

      shift_stage #(
         .DWIDTH (DWIDTH)
      ) u_stage (
         .i_clk  (i_clk),
         .i_rstn (i_rstn),
         .i_clr  (i_clr),
         .i_en   (i_en),
         .i_ld   (w_ld),
         .i_d    (w_nd[k]),
         .i_v    (w_nv[k]),
         .o_q    (w_s[k]),
         .o_v    (w_v[k])
      );

      assign o_pq[k*DWIDTH +: DWIDTH] = w_s[k];
   end

   assign o_q     = w_s[DEPTH-1];
   assign o_valid = w_v[DEPTH-1];

   // Tap select; codes beyond the last stage (non-power-of-two DEPTH) match
   // nothing and leave the tap at zero/invalid.
   always_comb begin
      o_tap       = '0;
      o_tap_valid = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         if (i_tap_sel == TWIDTH'(k)) begin
            o_tap       = w_s[k];
            o_tap_valid = w_v[k];
         end
      end
   end

endmodule

// File: tb/tb_shift_reg_pipe.sv
module tb_shift_reg_pipe;
   import shift_reg_pkg::*;

   logic        clk;
   logic        rstn;
   logic        clr;
   logic        en;
   logic [1:0]  mode;
   logic [7:0]  d;
   logic [31:0] pd4;
   logic [23:0] pd3;
   logic [1:0]  tap_sel;

   logic [7:0]  q4, tap4, q3, tap3;
   logic        v4, tv4, v3, tv3;
   logic [31:0] pq4;
   logic [23:0] pq3;

   int checks = 0;
   int errors = 0;

   // Reference state: stage contents as plain arrays, index 0 = input end
   logic [7:0] m4 [4];
   logic       mv4[4];
   logic [7:0] m3 [3];
   logic       mv3[3];

   shift_reg_pipe #(.DWIDTH(8), .DEPTH(4)) dut4 (
      .i_clk(clk), .i_rstn(rstn), .i_clr(clr), .i_en(en), .i_mode(mode),
      .i_d(d), .i_pd(pd4), .i_tap_sel(tap_sel),
      .o_q(q4), .o_valid(v4), .o_tap(tap4), .o_tap_valid(tv4), .o_pq(pq4)
   );

   shift_reg_pipe #(.DWIDTH(8), .DEPTH(3)) dut3 (
      .i_clk(clk), .i_rstn(rstn), .i_clr(clr), .i_en(en), .i_mode(mode),
      .i_d(d), .i_pd(pd3), .i_tap_sel(tap_sel),
      .o_q(q3), .o_valid(v3), .o_tap(tap3), .o_tap_valid(tv3), .o_pq(pq3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic       clr;
      logic       en;
      logic [1:0] mode;
      logic [7:0] d;
      logic [7:0] exp_q;
      logic       exp_v;
      logic [7:0] exp_tap;
      logic       exp_tv;
   } vec_t;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 4; k++) begin m4[k] = '0; mv4[k] = 1'b0; end
      for (int k = 0; k < 3; k++) begin m3[k] = '0; mv3[k] = 1'b0; end
   endtask

   // Behavioural view: a list of words that either gets a new head (shift),
   // gets its tail moved to the head (rotate), or is replaced wholesale (load).
   task automatic model_step();
      logic [7:0] t4 [4];
      logic       tv4a[4];
      logic [7:0] t3 [3];
      logic       tv3a[3];
      if (!rstn) begin
         model_reset();
         return;
      end
      if (clr) begin
         model_reset();
         return;
      end
      if (!en || mode == MODE_HOLD) return;
      t4 = m4; tv4a = mv4; t3 = m3; tv3a = mv3;
      case (mode)
         MODE_SHIFT: begin
            m4[0] = d; mv4[0] = 1'b1; m3[0] = d; mv3[0] = 1'b1;
            for (int k = 1; k < 4; k++) begin m4[k] = t4[k-1]; mv4[k] = tv4a[k-1]; end
            for (int k = 1; k < 3; k++) begin m3[k] = t3[k-1]; mv3[k] = tv3a[k-1]; end
         end
         MODE_ROTATE: begin
            for (int k = 0; k < 4; k++) begin m4[k] = t4[(k+3)%4]; mv4[k] = tv4a[(k+3)%4]; end
            for (int k = 0; k < 3; k++) begin m3[k] = t3[(k+2)%3]; mv3[k] = tv3a[(k+2)%3]; end
         end
         default: begin
            for (int k = 0; k < 4; k++) begin m4[k] = pd4[k*8 +: 8]; mv4[k] = 1'b1; end
            for (int k = 0; k < 3; k++) begin m3[k] = pd3[k*8 +: 8]; mv3[k] = 1'b1; end
         end
      endcase
   endtask

   task automatic check_model(input string tag);
      logic [31:0] e4;
      logic [23:0] e3;
      for (int k = 0; k < 4; k++) e4[k*8 +: 8] = m4[k];
      for (int k = 0; k < 3; k++) e3[k*8 +: 8] = m3[k];
      cmp({tag, ".q4"},   {24'd0, q4}, {24'd0, m4[3]});
      cmp({tag, ".v4"},   {31'd0, v4}, {31'd0, mv4[3]});
      cmp({tag, ".pq4"},  pq4, e4);
      cmp({tag, ".tap4"}, {23'd0, tv4, tap4}, {23'd0, mv4[tap_sel], m4[tap_sel]});
      cmp({tag, ".q3"},   {24'd0, q3}, {24'd0, m3[2]});
      cmp({tag, ".v3"},   {31'd0, v3}, {31'd0, mv3[2]});
      cmp({tag, ".pq3"},  {8'd0, pq3}, {8'd0, e3});
      if (tap_sel < 2'd3)
         cmp({tag, ".tap3"}, {23'd0, tv3, tap3}, {23'd0, mv3[tap_sel], m3[tap_sel]});
      else
         cmp({tag, ".tap3_oor"}, {23'd0, tv3, tap3}, 32'd0);
   endtask

   // One active edge: DUT and model both consume the current inputs; outputs
   // are sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   vec_t vt[17];

   initial begin
      rstn = 1'b0; clr = 1'b0; en = 1'b0; mode = MODE_HOLD;
      d = '0; pd4 = '0; pd3 = '0; tap_sel = '0;
      model_reset();
      #12;
      check_model("reset_init");
      rstn = 1'b1;

      // Reset release: first edge operates normally
      en = 1'b1; mode = MODE_SHIFT; d = 8'h5A;
      tick();
      cmp("rel_tap0", {23'd0, tv4, tap4}, {23'd0, 1'b1, 8'h5A});
      check_model("rel");

      // 1. async reset mid-cycle with pipe loaded with 0xAA
      mode = MODE_LOAD; pd4 = 32'hAAAA_AAAA; pd3 = 24'hAA_AAAA;
      tick();
      cmp("load_aa", pq4, 32'hAAAA_AAAA);
      mode = MODE_HOLD;
      #3;
      rstn = 1'b0;
      model_reset();
      #1;
      cmp("rst_q", {23'd0, v4, q4}, 32'd0);
      cmp("rst_pq", pq4, 32'd0);
      check_model("rst");
      #2;
      rstn = 1'b1;

      // 2/3. table-driven shift latency and enable gap
      vt[0]  = '{1, 1, MODE_SHIFT, 8'h00, 8'h00, 0, 8'h00, 0};
      vt[1]  = '{0, 1, MODE_SHIFT, 8'h11, 8'h00, 0, 8'h11, 1};
      vt[2]  = '{0, 1, MODE_SHIFT, 8'h22, 8'h00, 0, 8'h22, 1};
      vt[3]  = '{0, 1, MODE_SHIFT, 8'h33, 8'h00, 0, 8'h33, 1};
      vt[4]  = '{0, 1, MODE_SHIFT, 8'h44, 8'h11, 1, 8'h44, 1};
      vt[5]  = '{0, 1, MODE_SHIFT, 8'h55, 8'h22, 1, 8'h55, 1};
      vt[6]  = '{1, 1, MODE_SHIFT, 8'h00, 8'h00, 0, 8'h00, 0};
      vt[7]  = '{0, 1, MODE_SHIFT, 8'h11, 8'h00, 0, 8'h11, 1};
      vt[8]  = '{0, 1, MODE_SHIFT, 8'h22, 8'h00, 0, 8'h22, 1};
      vt[9]  = '{0, 0, MODE_SHIFT, 8'h99, 8'h00, 0, 8'h22, 1};
      vt[10] = '{0, 0, MODE_SHIFT, 8'h99, 8'h00, 0, 8'h22, 1};
      vt[11] = '{0, 1, MODE_SHIFT, 8'h33, 8'h00, 0, 8'h33, 1};
      vt[12] = '{0, 1, MODE_SHIFT, 8'h44, 8'h11, 1, 8'h44, 1};
      vt[13] = '{0, 1, MODE_SHIFT, 8'h55, 8'h22, 1, 8'h55, 1};
      vt[14] = '{0, 1, MODE_SHIFT, 8'h66, 8'h33, 1, 8'h66, 1};
      vt[15] = '{0, 1, MODE_SHIFT, 8'h77, 8'h44, 1, 8'h77, 1};
      vt[16] = '{0, 1, MODE_SHIFT, 8'h88, 8'h55, 1, 8'h88, 1};
      tap_sel = 2'd0;
      for (int i = 0; i < 17; i++) begin
         clr = vt[i].clr; en = vt[i].en; mode = vt[i].mode; d = vt[i].d;
         tick();
         cmp($sformatf("vec%0d.q", i), {23'd0, v4, q4}, {23'd0, vt[i].exp_v, vt[i].exp_q});
         cmp($sformatf("vec%0d.tap", i), {23'd0, tv4, tap4}, {23'd0, vt[i].exp_tv, vt[i].exp_tap});
      end
      clr = 1'b0;

      // 4. load then rotate
      en = 1'b1; mode = MODE_LOAD; pd4 = 32'h4433_2211; pd3 = 24'h33_2211;
      tick();
      cmp("ld.q", {23'd0, v4, q4}, {23'd0, 1'b1, 8'h44});
      cmp("ld.pq", pq4, 32'h4433_2211);
      mode = MODE_ROTATE;
      tick(); cmp("rot1", {23'd0, v4, q4}, {23'd0, 1'b1, 8'h33});
      tick(); cmp("rot2", {23'd0, v4, q4}, {23'd0, 1'b1, 8'h22});
      tick(); cmp("rot3", {23'd0, v4, q4}, {23'd0, 1'b1, 8'h11});
      tick(); cmp("rot4", {23'd0, v4, q4}, {23'd0, 1'b1, 8'h44});
      cmp("rot4.pq", pq4, 32'h4433_2211);

      // 6. tap sweep on the DEPTH=3 pipe: 1 rotation left it at 11,22,33 -> rotated
      mode = MODE_LOAD; pd3 = 24'h33_2211;
      tick();
      mode = MODE_HOLD;
      tap_sel = 2'd0; #1; cmp("sweep0", {23'd0, tv3, tap3}, {23'd0, 1'b1, 8'h11});
      tap_sel = 2'd1; #1; cmp("sweep1", {23'd0, tv3, tap3}, {23'd0, 1'b1, 8'h22});
      tap_sel = 2'd2; #1; cmp("sweep2", {23'd0, tv3, tap3}, {23'd0, 1'b1, 8'h33});
      tap_sel = 2'd3; #1; cmp("sweep3", {23'd0, tv3, tap3}, 32'd0);

      // 5. clear beats enable+load
      clr = 1'b1; en = 1'b1; mode = MODE_LOAD; pd4 = 32'hDEAD_BEEF; pd3 = 24'hAB_CDEF;
      tick();
      cmp("clr.pq", pq4, 32'd0);
      cmp("clr.v", {31'd0, v4}, 32'd0);
      check_model("clr");
      clr = 1'b0;

      // Randomized traffic against the reference model
      for (int i = 0; i < 400; i++) begin
         clr  = ($urandom_range(0, 15) == 0);
         en   = ($urandom_range(0, 3) != 0);
         mode = 2'($urandom_range(0, 3));
         d    = 8'($urandom);
         pd4  = $urandom;
         pd3  = 24'($urandom);
         tap_sel = 2'($urandom_range(0, 3));
         tick();
         check_model($sformatf("rnd%0d", i));
         // Mid-cycle input wiggle: tap follows at once, nothing else moves
         tap_sel = 2'($urandom_range(0, 3));
         d = 8'($urandom);
         #2;
         check_model($sformatf("rndtap%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
